// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_dir;
    logic             req0_usec;
    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_dir;
    logic             req1_usec;
    // responses
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_res;
    logic [3:0]       resp_flags;
    logic             carry_q;
    // ALU side
    logic [WIDTH-1:0] alu_reg1;
    logic [WIDTH-1:0] alu_reg2;
    logic [OPW-1:0]   alu_op;
    logic             alu_cin;
    logic             alu_dir;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_ovf;
    logic             alu_updc;

    // arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_dir, req0_usec,
        input  req1_valid, req1_op, req1_a, req1_b, req1_dir, req1_usec,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_res, resp_flags, carry_q,
        input  resp0_ready, resp1_ready,
        output alu_reg1, alu_reg2, alu_op, alu_cin, alu_dir,
        input  alu_res, alu_carry, alu_zero, alu_neg, alu_ovf, alu_updc
    );

    // requester / ALU side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_dir, req0_usec,
        output req1_valid, req1_op, req1_a, req1_b, req1_dir, req1_usec,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_res, resp_flags, carry_q,
        output resp0_ready, resp1_ready,
        input  alu_reg1, alu_reg2, alu_op, alu_cin, alu_dir,
        output alu_res, alu_carry, alu_zero, alu_neg, alu_ovf, alu_updc
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// owns the architectural carry register used for add-with-carry.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt_id;

    logic             grant_any;
    logic             grant;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_dir;
    logic             sel_usec;
    logic             resp_taken;

    // Arbitration: lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant     = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end

    // Ready is combinational so a request is accepted in the cycle it is seen.
    always_comb begin
        bus.req0_ready = (state == IDLE) & grant_any & ~grant;
        bus.req1_ready = (state == IDLE) & grant_any & grant;
    end

    // Payload of the requester being granted.
    always_comb begin
        sel_op   = grant ? bus.req1_op   : bus.req0_op;
        sel_a    = grant ? bus.req1_a    : bus.req0_a;
        sel_b    = grant ? bus.req1_b    : bus.req0_b;
        sel_dir  = grant ? bus.req1_dir  : bus.req0_dir;
        sel_usec = grant ? bus.req1_usec : bus.req0_usec;
    end

    // Response consumed by the requester that owns it.
    always_comb begin
        resp_taken = gnt_id ? bus.resp1_ready : bus.resp0_ready;
    end

    // Control FSM plus operand, result and carry registers.
    // carry_q cannot change between accept and EXEC, so the carry-in is
    // resolved at accept time and alu_cin stays a clean register output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            gnt_id          <= 1'b0;
            bus.resp0_valid <= 1'b0;
            bus.resp1_valid <= 1'b0;
            bus.resp_res    <= '0;
            bus.resp_flags  <= 4'b0000;
            bus.carry_q     <= 1'b0;
            bus.alu_reg1    <= '0;
            bus.alu_reg2    <= '0;
            bus.alu_op      <= '0;
            bus.alu_cin     <= 1'b0;
            bus.alu_dir     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.alu_op   <= sel_op;
                        bus.alu_reg1 <= sel_a;
                        bus.alu_reg2 <= sel_b;
                        bus.alu_dir  <= sel_dir;
                        bus.alu_cin  <= sel_usec & bus.carry_q;
                        gnt_id       <= grant;
                        last_grant   <= grant;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_res    <= bus.alu_res;
                    bus.resp_flags  <= {bus.alu_carry, bus.alu_zero, bus.alu_neg, bus.alu_ovf};
                    if (bus.alu_updc) begin
                        bus.carry_q <= bus.alu_carry;
                    end
                    bus.resp0_valid <= ~gnt_id;
                    bus.resp1_valid <= gnt_id;
                    state           <= RESP;
                end
                RESP: begin
                    if (resp_taken) begin
                        bus.resp0_valid <= 1'b0;
                        bus.resp1_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    bus.resp0_valid <= 1'b0;
                    bus.resp1_valid <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule
